// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, 8 data bits LSB first, optional parity, stop; tx_serial is registered.
// Start bit drives on the edge that samples the tx_sel rise; no backpressure, rises while busy are dropped.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434,
    parameter bit PARITY_EN    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       parity_sel,
    input  logic       tx_sel,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          sel_q;
    logic          serial_q, serial_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          baud_end;
    logic          launch;

    assign baud_end = (baud_q == BAUD_LAST);
    assign launch   = tx_sel & ~sel_q & (state_q == IDLE);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        serial_d = serial_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        if (state_q != IDLE) begin
            baud_d = baud_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d  = START;
                    shift_d  = tx_data;
                    // Parity bit value is resolved at capture so the shifter can consume the data.
                    par_d    = (^tx_data) ^ parity_sel;
                    serial_d = 1'b0;
                    busy_d   = 1'b1;
                    baud_d   = '0;
                    bit_d    = '0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d  = DATA;
                    serial_d = shift_q[0];
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        if (PARITY_EN) begin
                            state_d  = PARITY;
                            serial_d = par_q;
                        end else begin
                            state_d  = STOP;
                            serial_d = 1'b1;
                        end
                    end else begin
                        bit_d    = bit_q + 3'd1;
                        shift_d  = shift_q >> 1;
                        serial_d = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (baud_end) begin
                    state_d  = STOP;
                    serial_d = 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    state_d  = IDLE;
                    serial_d = 1'b1;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                serial_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            // Preset high so a level held through reset is not seen as a rising edge.
            sel_q    <= 1'b1;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            sel_q    <= tx_sel;
            serial_q <= serial_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx_serial = serial_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: directed frames with hand-computed bit sequences, checked by a frame monitor.
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tx_data, tx_data2;
    logic       parity_sel, parity_sel2;
    logic       tx_sel, tx_sel2;
    logic       tx_serial, tx_busy, tx_done;
    logic       tx_serial2, tx_busy2, tx_done2;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    // seq holds the frame as listed on the wire: seq[nbits-1] is the start bit.
    typedef struct {
        int          nbits;
        logic [10:0] seq;
        int          len;
        bit          abort;
        int          gap;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int          in_frame [2];
    int          cnt      [2];
    int          idle     [2];
    int          gap_seen [2];
    logic [63:0] samp     [2];

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data),
        .parity_sel (parity_sel),
        .tx_sel     (tx_sel),
        .tx_serial  (tx_serial),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut_np (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_data    (tx_data2),
        .parity_sel (parity_sel2),
        .tx_sel     (tx_sel2),
        .tx_serial  (tx_serial2),
        .tx_busy    (tx_busy2),
        .tx_done    (tx_done2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int nbits, input logic [10:0] seq, input int len,
                                input bit abort, input int gap);
        exp_t e;
        e.nbits = nbits;
        e.seq   = seq;
        e.len   = len;
        e.abort = abort;
        e.gap   = gap;
        return e;
    endfunction

    task automatic mon(input int i, input logic ser, input logic busy, input logic done);
        exp_t e;
        int   bad;
        bit   have;
        if (busy === 1'b1) begin
            if (in_frame[i] == 0) begin
                in_frame[i] = 1;
                cnt[i]      = 0;
                gap_seen[i] = idle[i];
            end
            if (cnt[i] < 64) samp[i][cnt[i]] = ser;
            cnt[i]++;
        end else if (in_frame[i] != 0) begin
            in_frame[i] = 0;
            idle[i]     = 1;
            have        = (i == 0) ? (q0.size() != 0) : (q1.size() != 0);
            if (!have) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame dut%0d: frame of %0d cycles, none expected", i, cnt[i]);
            end else begin
                if (i == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk($sformatf("busy_cycles_dut%0d", i), cnt[i], e.len);
                bad = -1;
                for (int k = 0; k < cnt[i] && k < 64; k++) begin
                    int b;
                    b = k / CPB;
                    if (bad < 0 && (b >= e.nbits || samp[i][k] !== e.seq[e.nbits-1-b])) bad = k;
                end
                chk($sformatf("first_bad_sample_dut%0d", i), bad, -1);
                chk($sformatf("done_at_busy_fall_dut%0d", i), (done === 1'b1) ? 1 : 0, e.abort ? 0 : 1);
                chk($sformatf("line_high_at_busy_fall_dut%0d", i), (ser === 1'b1) ? 1 : 0, 1);
                if (e.gap >= 0) chk($sformatf("idle_gap_dut%0d", i), gap_seen[i], e.gap);
            end
        end else begin
            idle[i]++;
            checks++;
            if (done !== 1'b0 || ser !== 1'b1) begin
                failures++;
                $display("FAIL idle_line_dut%0d: serial=%b done=%b, expected serial=1 done=0", i, ser, done);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, tx_serial, tx_busy, tx_done);
            mon(1, tx_serial2, tx_busy2, tx_done2);
        end
    end

    task automatic launch(input int i, input logic [7:0] d, input logic ps);
        @(posedge clk); #1;
        if (i == 0) begin tx_data = d;  parity_sel = ps;  tx_sel = 1'b1;  end
        else        begin tx_data2 = d; parity_sel2 = ps; tx_sel2 = 1'b1; end
        @(posedge clk); #1;
        if (i == 0) tx_sel = 1'b0;
        else        tx_sel2 = 1'b0;
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 2; i++) begin
            in_frame[i] = 0; cnt[i] = 0; idle[i] = 0; gap_seen[i] = 0; samp[i] = '0;
        end
        rst_n = 1'b0;
        tx_data = 8'h00; parity_sel = 1'b0; tx_sel = 1'b0;
        tx_data2 = 8'h00; parity_sel2 = 1'b0; tx_sel2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Idle after reset
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("idle_after_reset{serial,busy,done}", {tx_serial, tx_busy, tx_done}, 3'b100);
        end

        // 0xA5 even parity
        q0.push_back(mk(11, 11'b0_10100101_0_1, 44, 1'b0, -1));
        launch(0, 8'hA5, 1'b0);
        repeat (50) @(posedge clk);

        // 0x07 odd, then even, then no-parity instance
        q0.push_back(mk(11, 11'b0_11100000_0_1, 44, 1'b0, -1));
        launch(0, 8'h07, 1'b1);
        repeat (50) @(posedge clk);
        q0.push_back(mk(11, 11'b0_11100000_1_1, 44, 1'b0, -1));
        launch(0, 8'h07, 1'b0);
        repeat (50) @(posedge clk);
        q1.push_back(mk(10, 11'b0_0_11100000_1, 40, 1'b0, -1));
        launch(1, 8'h07, 1'b0);
        repeat (50) @(posedge clk);

        // 0x55 with input churn mid-frame
        q0.push_back(mk(11, 11'b0_10101010_0_1, 44, 1'b0, -1));
        launch(0, 8'h55, 1'b0);
        repeat (8) @(posedge clk);
        #1 tx_data = 8'hFF; parity_sel = 1'b1; tx_sel = 1'b1;
        repeat (6) @(posedge clk);
        #1 tx_sel = 1'b0;
        repeat (4) @(posedge clk);
        #1 tx_sel = 1'b1;
        repeat (6) @(posedge clk);
        #1 tx_sel = 1'b0;
        repeat (60) @(posedge clk);

        // Back-to-back: 0x3C then 0xC3 launched in the done cycle
        q0.push_back(mk(11, 11'b0_00111100_0_1, 44, 1'b0, -1));
        q0.push_back(mk(11, 11'b0_11000011_0_1, 44, 1'b0, 1));
        launch(0, 8'h3C, 1'b0);
        found = 1'b0;
        for (int c = 0; c < 80 && !found; c++) begin
            @(posedge clk); #1;
            if (tx_done === 1'b1) begin
                found = 1'b1;
                tx_data = 8'hC3; parity_sel = 1'b0; tx_sel = 1'b1;
            end
        end
        chk("done_seen_before_b2b", found, 1);
        @(posedge clk); #1 tx_sel = 1'b0;
        repeat (60) @(posedge clk);

        // Reset during data bit 3 of 0x96, then tx_sel held through reset release
        q0.push_back(mk(11, 11'b0_01101001_0_1, 18, 1'b1, -1));
        launch(0, 8'h96, 1'b0);
        repeat (17) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_edge{serial,busy,done}", {tx_serial, tx_busy, tx_done}, 3'b100);
        tx_sel = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            chk("no_launch_sel_held{serial,busy}", {tx_serial, tx_busy}, 2'b10);
        end
        tx_sel = 1'b0;
        repeat (5) @(posedge clk);

        chk("expected_frames_left_dut0", q0.size(), 0);
        chk("expected_frames_left_dut1", q1.size(), 0);
        chk("frame_open_at_end_dut0", in_frame[0], 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
